scr1_imem_opcode_monitor: RTL
=============================

// Module: scr1_imem_opcode_monitor
// PURPOSE
//  Passive monitor on the core's IMEM response path. Classifies every valid fetched word against
//  N_CH match/mask channels and counts hits per channel in saturating counters. Queues
//  {channel id, fetch PC} for each hit in an event FIFO, drained by the testbench or a debug reader.
//  Replaces single-opcode ad-hoc detectors with one configurable, synthesizable block.
// PARAMETERS
//  N_CH        4                       number of match channels (1..8)
//  CH_MATCH    {N_CH{32'h0000_1063}}   packed N_CH x 32 match values; channel k = bits [32k+31:32k]
//  CH_MASK     {N_CH{32'h0000_707F}}   packed N_CH x 32 masks; 1 = bit is compared
//  CNT_W       16                      hit-counter width
//  FIFO_DEPTH  8                       event FIFO entries; power of two, >= 2
// PORTS
//  clk            in   1           core clock
//  rst            in   1           synchronous reset, active-high
//  imem_resp_i    in   2           IMEM response: 2'b01 OKAY (valid), 2'b00 IDLE, 2'b10 ERROR
//  imem_rdata_i   in   32          fetched instruction word
//  curr_pc_i      in   32          pipe current PC, sampled in the same cycle as the response
//  clr_i          in   1           clear all counters, FIFO and sticky flags
//  evt_rdy_i      in   1           consumer ready to pop the FIFO head
//  evt_vld_o      out  1           FIFO non-empty
//  evt_ch_o       out  3           channel id of the FIFO head
//  evt_pc_o       out  32          PC of the FIFO head
//  hit_cnt_o      out  N_CH*CNT_W  packed per-channel hit counters
//  ovf_o          out  1           sticky: an event was dropped because the FIFO was full
//  err_o          out  1           sticky: an IMEM ERROR response was observed
// BEHAVIOUR
//  - Reset and clr_i: all counters 0, FIFO empty (evt_vld_o=0, evt_ch_o=0, evt_pc_o=0), ovf_o=0, err_o=0.
//    clr_i has priority over every same-cycle update.
//  - Qualify: valid = (imem_resp_i==2'b01). hit[k] = valid & ((imem_rdata_i & MASK[k]) == (MATCH[k] & MASK[k])).
//  - Counters: every channel with hit[k] increments in the next cycle (1-cycle latency).
//    A counter saturates at all-ones and never wraps.
//  - Events: one event per valid word at most. ch = lowest k with hit[k] set (fixed priority).
//    pc = curr_pc_i. The event is pushed at the clock edge of the hit. It is visible on evt_*_o
//    the next cycle if the FIFO was empty (no fall-through).
//  - Pop: evt_vld_o & evt_rdy_i pops the head at the edge. Head outputs are held stable while
//    evt_vld_o=1 and evt_rdy_i=0.
//  - Full: a push into a full FIFO is dropped and ovf_o is set. Exception: a push and a pop in
//    the same cycle when full both succeed, with no overflow.
//  - Empty: a pop request with evt_vld_o=0 is ignored. A push and a pop in the same cycle when
//    empty perform only the push.
//  - Pointers are log2(FIFO_DEPTH)+1 bits wide. They wrap naturally.
//    full = MSBs differ and the rest are equal; empty = pointers equal.
//  - err_o is set on imem_resp_i==2'b10 and cleared only by rst or clr_i. rdata is ignored on ERROR/IDLE.
//  - Reset asserted mid-stream discards all pending events. It has the same effect as clr_i.
//  - No outputs feed back into the core. The block is purely observational.
// STRUCTURE
//  - Shared package scr1_mon_pkg: type scr1_mon_evt_s {logic [2:0] ch; logic [31:0] pc;},
//    localparam SCR1_IMEM_RESP_OKAY=2'b01, SCR1_IMEM_RESP_ERR=2'b10, default BNE match/mask constants.
//  - One sub-module: scr1_mon_evt_fifo (parametrised sync FIFO of scr1_mon_evt_s with push/pop/full/empty).
//    Classifier, priority encoder and counters stay in the top.
// TESTING
//  1. Reset, then IDLE for 10 cycles -> all counters 0, evt_vld_o=0, ovf_o=0, err_o=0.
//  2. CH0 = BNE (match 0x1063, mask 0x707F). OKAY rdata=0x00B51463, pc=0x200 -> next cycle
//     cnt0=1, evt_vld_o=1, ch=0, pc=0x200.
//  3. Overlap: CH1 mask 0x7F, match 0x63 (all branches). Drive the BNE word -> cnt0=1, cnt1=1,
//     one event with ch=0. Then BEQ 0x00B50463 -> cnt1=2, event ch=1.
//  4. evt_rdy_i=0; 9 BNE words at pc 0x100..0x120 -> 8 queued, ovf_o=1. Then drain with
//     evt_rdy_i=1 -> PCs 0x100..0x11C in order, then evt_vld_o=0.
//  5. FIFO full and evt_rdy_i=1 while a BNE arrives -> occupancy stays 8, ovf_o stays 0.
//     Then assert clr_i -> empty, counters 0.
//  6. CNT_W=4: 17 BNE hits -> cnt0=15 (saturated). An ERROR response with rdata=0x00B51463
//     -> err_o=1 and the counter is unchanged.

Source files
------------

// File: rtl/scr1_mon_pkg.sv
// Shared types and constants for the IMEM opcode monitor: event record,
// IMEM response encodings and the default (BNE) match/mask pair.
package scr1_mon_pkg;

   typedef struct packed {
      logic [2:0]  ch;
      logic [31:0] pc;
   } scr1_mon_evt_s;

   localparam logic [1:0]  SCR1_IMEM_RESP_OKAY = 2'b01;
   localparam logic [1:0]  SCR1_IMEM_RESP_ERR  = 2'b10;

   localparam logic [31:0] SCR1_MON_BNE_MATCH  = 32'h0000_1063;
   localparam logic [31:0] SCR1_MON_BNE_MASK   = 32'h0000_707F;

endpackage

// File: rtl/scr1_mon_evt_fifo.sv
// Synchronous event FIFO with extra-MSB pointers. A push into a full FIFO is
// accepted only when the head is popped in the same cycle; otherwise it is dropped.
module scr1_mon_evt_fifo
   import scr1_mon_pkg::*;
#(
   parameter int DEPTH = 8
)
(
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  scr1_mon_evt_s push_data,
   input  logic          pop,
   output scr1_mon_evt_s head,
   output logic          full,
   output logic          empty,
   output logic          drop
);

   localparam int AW = $clog2(DEPTH);

   scr1_mon_evt_s mem [DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          push_en;
   logic          pop_en;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop_en  = pop & ~empty;
   assign push_en = push & (~full | pop_en);
   assign drop    = push & full & ~pop_en;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_en) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop_en)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push_en) mem[wr_ptr[AW-1:0]] <= push_data;
   end

   assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/scr1_imem_opcode_monitor.sv
// Passive IMEM response monitor: classifies valid fetched words against N_CH
// match/mask channels, keeps saturating hit counters and queues {ch, pc} events.
module scr1_imem_opcode_monitor
   import scr1_mon_pkg::*;
#(
   parameter int                   N_CH       = 4,
   parameter logic [N_CH*32-1:0]   CH_MATCH   = {N_CH{SCR1_MON_BNE_MATCH}},
   parameter logic [N_CH*32-1:0]   CH_MASK    = {N_CH{SCR1_MON_BNE_MASK}},
   parameter int                   CNT_W      = 16,
   parameter int                   FIFO_DEPTH = 8
)
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [1:0]              imem_resp_i,
   input  logic [31:0]             imem_rdata_i,
   input  logic [31:0]             curr_pc_i,
   input  logic                    clr_i,
   input  logic                    evt_rdy_i,
   output logic                    evt_vld_o,
   output logic [2:0]              evt_ch_o,
   output logic [31:0]             evt_pc_o,
   output logic [N_CH*CNT_W-1:0]   hit_cnt_o,
   output logic                    ovf_o,
   output logic                    err_o
);

   logic                valid;
   logic [N_CH-1:0]     hit;
   logic [2:0]          hit_ch;
   logic                flush;
   logic [CNT_W-1:0]    cnt [N_CH];
   scr1_mon_evt_s       push_evt;
   scr1_mon_evt_s       head_evt;
   logic                fifo_full;
   logic                fifo_empty;
   logic                fifo_drop;

   assign valid = (imem_resp_i == SCR1_IMEM_RESP_OKAY);
   assign flush = rst | clr_i;

   always_comb begin
      hit = '0;
      for (int k = 0; k < N_CH; k++) begin
         hit[k] = valid & ((imem_rdata_i & CH_MASK[32*k +: 32]) ==
                           (CH_MATCH[32*k +: 32] & CH_MASK[32*k +: 32]));
      end
   end

   // Descending scan so the lowest-numbered hitting channel wins.
   always_comb begin
      hit_ch = '0;
      for (int k = N_CH-1; k >= 0; k--) begin
         if (hit[k]) hit_ch = 3'(k);
      end
   end

   always_ff @(posedge clk) begin
      if (flush) begin
         for (int k = 0; k < N_CH; k++) cnt[k] <= '0;
      end else begin
         for (int k = 0; k < N_CH; k++) begin
            if (hit[k] && (cnt[k] != {CNT_W{1'b1}})) cnt[k] <= cnt[k] + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (flush) begin
         ovf_o <= 1'b0;
         err_o <= 1'b0;
      end else begin
         if (fifo_drop) ovf_o <= 1'b1;
         if (imem_resp_i == SCR1_IMEM_RESP_ERR) err_o <= 1'b1;
      end
   end

   assign push_evt.ch = hit_ch;
   assign push_evt.pc = curr_pc_i;

   scr1_mon_evt_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_evt_fifo (
      .clk       (clk),
      .rst       (flush),
      .push      (|hit),
      .push_data (push_evt),
      .pop       (evt_rdy_i),
      .head      (head_evt),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .drop      (fifo_drop)
   );

   assign evt_vld_o = ~fifo_empty;
   assign evt_ch_o  = head_evt.ch;
   assign evt_pc_o  = head_evt.pc;

   for (genvar g = 0; g < N_CH; g++) begin : g_cnt_out
      assign hit_cnt_o[CNT_W*g +: CNT_W] = cnt[g];
   end

endmodule
